// File: rtl/lcd_sprite_scheduler_pkg.sv
// Shared types and helpers for the LCD sprite redraw scheduler.
// States, sprite ids, rectangle bundle, RGB565 colours, saturating math.
package lcd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLEAR_WAIT,
        ST_ERASE,
        ST_ERASE_WAIT,
        ST_DRAW,
        ST_DRAW_WAIT
    } state_e;

    typedef enum logic {
        SPR_BALL   = 1'b0,
        SPR_PADDLE = 1'b1
    } sprite_e;

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] y0;
        logic [8:0] x1;
        logic [8:0] y1;
    } rect_t;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;

    function automatic logic [9:0] sat_min(
        input logic [9:0] a,
        input logic [9:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] sat_max(
        input logic [9:0] a,
        input logic [9:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_sprite_scheduler_if.sv
// Rectangle command channel between the scheduler and the fill engine.
// valid/ready command handshake plus a one-cycle fill_done completion.
interface lcd_sprite_scheduler_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x0;
    logic [8:0]  cmd_y0;
    logic [8:0]  cmd_x1;
    logic [8:0]  cmd_y1;
    logic [15:0] cmd_color;
    logic        fill_done;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, fill_done
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, fill_done
    );

endinterface

// File: rtl/lcd_sprite_scheduler_rect_calc.sv
// Combinational sprite position to clipped screen rectangle.
// Intermediates are 10 bits wide so nothing wraps before clipping.
module sprite_rect_calc
    import lcd_sched_pkg::*;
#(
    parameter int SCREEN_W  = 240,
    parameter int SCREEN_H  = 320,
    parameter int BALL_X    = 112,
    parameter int BALL_SIZE = 16,
    parameter int PADDLE_Y  = 300,
    parameter int PADDLE_W  = 48,
    parameter int PADDLE_H  = 8
) (
    input  sprite_e    sprite,
    input  logic [8:0] pos,
    output rect_t      rect
);

    localparam logic [9:0] W_MAX   = 10'(SCREEN_W - 1);
    localparam logic [9:0] H_MAX   = 10'(SCREEN_H - 1);
    localparam logic [9:0] BS_M1   = 10'(BALL_SIZE - 1);
    localparam logic [9:0] PW_M1   = 10'(PADDLE_W - 1);
    localparam logic [9:0] PW_HALF = 10'(PADDLE_W / 2);
    localparam logic [8:0] BX0     = 9'(BALL_X);
    localparam logic [8:0] BX1     = 9'(BALL_X + BALL_SIZE - 1);
    localparam logic [8:0] PY0     = 9'(PADDLE_Y);
    localparam logic [8:0] PY1     = 9'(PADDLE_Y + PADDLE_H - 1);

    logic [9:0] pos10;
    logic [9:0] by0;
    logic [9:0] by1;
    logic [9:0] px0;
    logic [9:0] px1;
    logic       unused_hi;

    assign unused_hi = ^{by0[9], by1[9], px0[9], px1[9]};

    // Clip both sprite shapes, then pick the one asked for.
    always_comb begin
        pos10 = {1'b0, pos};
        by0   = sat_min(pos10, H_MAX);
        by1   = sat_min(by0 + BS_M1, H_MAX);
        px0   = sat_max(pos10, PW_HALF) - PW_HALF;
        px1   = sat_min(px0 + PW_M1, W_MAX);
        rect  = '0;
        if (sprite == SPR_BALL) begin
            rect.x0 = BX0;
            rect.x1 = BX1;
            rect.y0 = by0[8:0];
            rect.y1 = by1[8:0];
        end else begin
            rect.x0 = px0[8:0];
            rect.x1 = px1[8:0];
            rect.y0 = PY0;
            rect.y1 = PY1;
        end
    end

endmodule

// File: rtl/lcd_sprite_scheduler.sv
// Ball/paddle redraw scheduler feeding the LCD rectangle-fill engine.
// Optional LCD_SCHED_INIT_CLEAR_EN: full-screen clear after reset.
module lcd_sprite_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int          SCREEN_W     = 240,
    parameter int          SCREEN_H     = 320,
    parameter int          BALL_X       = 112,
    parameter int          BALL_SIZE    = 16,
    parameter int          PADDLE_Y     = 300,
    parameter int          PADDLE_W     = 48,
    parameter int          PADDLE_H     = 8,
    parameter logic [15:0] BG_COLOR     = RGB565_BLACK,
    parameter logic [15:0] BALL_COLOR   = RGB565_RED,
    parameter logic [15:0] PADDLE_COLOR = RGB565_GREEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic [8:0]                    ball_y,
    input  logic [8:0]                    hand_x,
    lcd_sprite_scheduler_if.master        cmd,
    output logic                          busy
);

`ifdef LCD_SCHED_INIT_CLEAR_EN
    localparam state_e RESET_ST = ST_CLEAR;
    localparam rect_t  FULL_RECT = '{
        x0: 9'd0,
        y0: 9'd0,
        x1: 9'(SCREEN_W - 1),
        y1: 9'(SCREEN_H - 1)
    };
`else
    localparam state_e RESET_ST = ST_IDLE;
`endif

    state_e      state_q, state_d;
    logic        samp_valid_q, samp_valid_d;
    logic [8:0]  samp_y_q, samp_y_d;
    logic [8:0]  samp_x_q, samp_x_d;
    logic [8:0]  drawn_y_q, drawn_y_d;
    logic [8:0]  drawn_x_q, drawn_x_d;
    logic        dv_ball_q, dv_ball_d;
    logic        dv_pad_q, dv_pad_d;
    sprite_e     last_q, last_d;
    sprite_e     spr_q, spr_d;
    logic [8:0]  target_q, target_d;
    logic        cmd_valid_q, cmd_valid_d;
    rect_t       rect_q, rect_d;
    logic [15:0] color_q, color_d;

    logic        pend_ball;
    logic        pend_pad;
    logic        grant_any;
    sprite_e     gnt;
    sprite_e     sel;
    logic [8:0]  old_pos;
    logic [8:0]  tgt_pos;
    logic        sel_dv;
    logic [15:0] spr_color;
    logic        handshake;
    rect_t       old_rect;
    rect_t       tgt_rect;

    // Pending detection, round-robin grant and job operand selection.
    always_comb begin
        pend_ball = samp_valid_q & (!dv_ball_q | (samp_y_q != drawn_y_q));
        pend_pad  = samp_valid_q & (!dv_pad_q | (samp_x_q != drawn_x_q));
        grant_any = (state_q == ST_IDLE) & (pend_ball | pend_pad);
        gnt       = SPR_BALL;
        if (pend_ball & pend_pad) begin
            gnt = (last_q == SPR_PADDLE) ? SPR_BALL : SPR_PADDLE;
        end else if (pend_pad) begin
            gnt = SPR_PADDLE;
        end
        sel     = (state_q == ST_IDLE) ? gnt : spr_q;
        old_pos = (sel == SPR_BALL) ? drawn_y_q : drawn_x_q;
        sel_dv  = (sel == SPR_BALL) ? dv_ball_q : dv_pad_q;
        tgt_pos = target_q;
        if (state_q == ST_IDLE) begin
            tgt_pos = (gnt == SPR_BALL) ? samp_y_q : samp_x_q;
        end
        spr_color = (sel == SPR_BALL) ? BALL_COLOR : PADDLE_COLOR;
        handshake = cmd_valid_q & cmd.cmd_ready;
    end

    sprite_rect_calc #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_X    (BALL_X),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_Y  (PADDLE_Y),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H)
    ) u_old_rect (
        .sprite (sel),
        .pos    (old_pos),
        .rect   (old_rect)
    );

    sprite_rect_calc #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_X    (BALL_X),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_Y  (PADDLE_Y),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H)
    ) u_tgt_rect (
        .sprite (sel),
        .pos    (tgt_pos),
        .rect   (tgt_rect)
    );

    // Next-state: position sampling plus the erase/draw job sequencer.
    always_comb begin
        state_d      = state_q;
        samp_valid_d = samp_valid_q;
        samp_y_d     = samp_y_q;
        samp_x_d     = samp_x_q;
        drawn_y_d    = drawn_y_q;
        drawn_x_d    = drawn_x_q;
        dv_ball_d    = dv_ball_q;
        dv_pad_d     = dv_pad_q;
        last_d       = last_q;
        spr_d        = spr_q;
        target_d     = target_q;
        cmd_valid_d  = cmd_valid_q;
        rect_d       = rect_q;
        color_d      = color_q;

        if (frame_tick) begin
            samp_valid_d = 1'b1;
            samp_y_d     = ball_y;
            samp_x_d     = hand_x;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    spr_d       = gnt;
                    target_d    = tgt_pos;
                    cmd_valid_d = 1'b1;
                    if (sel_dv) begin
                        state_d = ST_ERASE;
                        rect_d  = old_rect;
                        color_d = BG_COLOR;
                    end else begin
                        state_d = ST_DRAW;
                        rect_d  = tgt_rect;
                        color_d = spr_color;
                    end
                end
            end
            ST_ERASE: begin
                if (handshake) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_ERASE_WAIT;
                end
            end
            ST_ERASE_WAIT: begin
                if (cmd.fill_done) begin
                    state_d     = ST_DRAW;
                    cmd_valid_d = 1'b1;
                    rect_d      = tgt_rect;
                    color_d     = spr_color;
                end
            end
            ST_DRAW: begin
                if (handshake) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_DRAW_WAIT;
                end
            end
            ST_DRAW_WAIT: begin
                if (cmd.fill_done) begin
                    if (spr_q == SPR_BALL) begin
                        drawn_y_d = target_q;
                        dv_ball_d = 1'b1;
                    end else begin
                        drawn_x_d = target_q;
                        dv_pad_d  = 1'b1;
                    end
                    last_d  = spr_q;
                    state_d = ST_IDLE;
                end
            end
`ifdef LCD_SCHED_INIT_CLEAR_EN
            ST_CLEAR: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    rect_d      = FULL_RECT;
                    color_d     = BG_COLOR;
                end else if (cmd.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_CLEAR_WAIT;
                end
            end
            ST_CLEAR_WAIT: begin
                if (cmd.fill_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered command outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_ST;
            samp_valid_q <= 1'b0;
            samp_y_q     <= '0;
            samp_x_q     <= '0;
            drawn_y_q    <= '0;
            drawn_x_q    <= '0;
            dv_ball_q    <= 1'b0;
            dv_pad_q     <= 1'b0;
            last_q       <= SPR_PADDLE;
            spr_q        <= SPR_BALL;
            target_q     <= '0;
            cmd_valid_q  <= 1'b0;
            rect_q       <= '0;
            color_q      <= '0;
        end else begin
            state_q      <= state_d;
            samp_valid_q <= samp_valid_d;
            samp_y_q     <= samp_y_d;
            samp_x_q     <= samp_x_d;
            drawn_y_q    <= drawn_y_d;
            drawn_x_q    <= drawn_x_d;
            dv_ball_q    <= dv_ball_d;
            dv_pad_q     <= dv_pad_d;
            last_q       <= last_d;
            spr_q        <= spr_d;
            target_q     <= target_d;
            cmd_valid_q  <= cmd_valid_d;
            rect_q       <= rect_d;
            color_q      <= color_d;
        end
    end

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_x0    = rect_q.x0;
    assign cmd.cmd_y0    = rect_q.y0;
    assign cmd.cmd_x1    = rect_q.x1;
    assign cmd.cmd_y1    = rect_q.y1;
    assign cmd.cmd_color = color_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_sprite_scheduler.sv
// Scoreboard bench for lcd_sprite_scheduler with a fill-engine model.
// Define LCD_SCHED_INIT_CLEAR_EN to expect the post-reset clear.
module tb_lcd_sprite_scheduler;

    typedef struct packed {
        logic [8:0]  x0;
        logic [8:0]  y0;
        logic [8:0]  x1;
        logic [8:0]  y1;
        logic [15:0] c;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [8:0] ball_y = '0;
    logic [8:0] hand_x = '0;
    logic       busy;
    logic       ready = 1'b1;
    logic       eng_done = 1'b0;
    logic       spur_done = 1'b0;
    logic       hold_draw = 1'b0;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    lcd_sprite_scheduler_if cif ();

    assign cif.cmd_ready = ready;
    assign cif.fill_done = eng_done | spur_done;

    lcd_sprite_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .ball_y     (ball_y),
        .hand_x     (hand_x),
        .cmd        (cif.master),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int x0, input int y0, input int x1,
                        input int y1, input logic [15:0] c);
        cmd_t e;
        e.x0 = 9'(x0);
        e.y0 = 9'(y0);
        e.x1 = 9'(x1);
        e.y1 = 9'(y1);
        e.c  = c;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int by, input int hx);
        @(posedge clk);
        #2;
        ball_y     = 9'(by);
        hand_x     = 9'(hx);
        frame_tick = 1'b1;
        @(posedge clk);
        #2;
        frame_tick = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s: timeout, %0d commands outstanding, busy=%0b",
                     nm, exp_q.size(), busy);
        end
    endtask

    // Monitor and fill-engine model: compare each accepted command.
    initial begin
        cmd_t got;
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cif.cmd_valid && ready) begin
                got.x0 = cif.cmd_x0;
                got.y0 = cif.cmd_y0;
                got.x1 = cif.cmd_x1;
                got.y1 = cif.cmd_y1;
                got.c  = cif.cmd_color;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got %0h expected none",
                             got);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", {12'b0, got}, {12'b0, e});
                end
                @(posedge clk);
                if (!(hold_draw && got.c != 16'h0000)) begin
                    @(posedge clk);
                    #2;
                    if (rst_n) eng_done = 1'b1;
                    @(posedge clk);
                    #2;
                    eng_done = 1'b0;
                end
            end
        end
    end

    // Directed stimulus; expectations are pushed before each tick.
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 64'(cif.cmd_valid), 64'd0);
        chk("rst_rect", {28'b0, cif.cmd_x0, cif.cmd_y0, cif.cmd_x1,
            cif.cmd_y1}, 64'd0);
        chk("rst_color", 64'(cif.cmd_color), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
`ifdef LCD_SCHED_INIT_CLEAR_EN
        push(0, 0, 239, 319, 16'h0000);
`endif

        push(112, 100, 127, 115, 16'hF800);
        push(96, 300, 143, 307, 16'h07E0);
        tick(100, 120);
        wait_done("first_draw");

        push(112, 100, 127, 115, 16'h0000);
        push(112, 110, 127, 125, 16'hF800);
        tick(110, 120);
        wait_done("ball_move");

        push(96, 300, 143, 307, 16'h0000);
        push(0, 300, 47, 307, 16'h07E0);
        push(112, 110, 127, 125, 16'h0000);
        push(112, 315, 127, 319, 16'hF800);
        tick(315, 5);
        wait_done("both_move_sat");

        @(posedge clk);
        #2;
        spur_done = 1'b1;
        @(posedge clk);
        #2;
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_spur_busy", 64'(busy), 64'd0);

        ready = 1'b0;
        push(112, 315, 127, 319, 16'h0000);
        push(112, 200, 127, 215, 16'hF800);
        tick(200, 5);
        n = 0;
        while (!cif.cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_rise", 64'(n < 20), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            spur_done = 1'b0;
            chk("stall_valid", 64'(cif.cmd_valid), 64'd1);
            chk("stall_cmd", {12'b0, cif.cmd_x0, cif.cmd_y0, cif.cmd_x1,
                cif.cmd_y1, cif.cmd_color},
                {12'b0, 9'd112, 9'd315, 9'd127, 9'd319, 16'h0000});
            if (i == 3) spur_done = 1'b1;
        end
        chk("stall_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2;
        ready = 1'b1;
        wait_done("stall_release");

        hold_draw = 1'b1;
        push(112, 200, 127, 215, 16'h0000);
        push(112, 150, 127, 165, 16'hF800);
        tick(150, 5);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("draw_wait_reach", 64'(n < 200), 64'd1);
        repeat (2) @(negedge clk);
        chk("draw_wait_busy", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(cif.cmd_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cmd", {12'b0, cif.cmd_x0, cif.cmd_y0, cif.cmd_x1,
            cif.cmd_y1, cif.cmd_color}, 64'd0);
        @(posedge clk);
        #2;
        hold_draw = 1'b0;
        rst_n     = 1'b1;
`ifdef LCD_SCHED_INIT_CLEAR_EN
        push(0, 0, 239, 319, 16'h0000);
`endif
        push(112, 50, 127, 65, 16'hF800);
        push(96, 300, 143, 307, 16'h07E0);
        tick(50, 120);
        wait_done("post_reset");

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
